// File: rtl/stage2_pool_collector.sv
// ---------------------------------------------------------------------------
// stage2_pool_collector
//   Captures a full POOL_W x POOL_H frame of CI-channel pooled points (valid
//   strobed, no backpressure), then drains it channel-major as one signed
//   element per beat over a valid/ready stream.
//
// Ports
//   clk, reset_n     clock, synchronous active-low reset
//   i_clear          synchronous soft clear (same effect as reset)
//   i_in_valid       pooled point present this cycle
//   i_in_fmap        point vector, channel ch at [ch*IBW +: IBW]
//   o_ot_valid       flattened element valid
//   i_ot_ready       downstream accepts element
//   o_ot_data        flattened element (signed)
//   o_ot_index       flattened index ch*POOL_H*POOL_W + p
//   o_ot_last        high with the final element
//   o_frame_done     one-cycle pulse after the last handshake
//   o_overflow       sticky: a point arrived while draining and was dropped
// ---------------------------------------------------------------------------
module stage2_pool_collector #(
    parameter int CI     = 3,
    parameter int IBW    = 19,
    parameter int POOL_W = 4,
    parameter int POOL_H = 4,
    parameter int IDX_BW = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_clear,
    input  logic                  i_in_valid,
    input  logic [CI*IBW-1:0]     i_in_fmap,
    output logic                  o_ot_valid,
    input  logic                  i_ot_ready,
    output logic [IBW-1:0]        o_ot_data,
    output logic [IDX_BW-1:0]     o_ot_index,
    output logic                  o_ot_last,
    output logic                  o_frame_done,
    output logic                  o_overflow
);

    localparam int NPTS  = POOL_W * POOL_H;
    localparam int TOTAL = CI * NPTS;
    localparam int PT_BW = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int CH_BW = (CI > 1) ? $clog2(CI) : 1;

    typedef enum logic {
        COLLECT,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [CI*IBW-1:0] mem [NPTS];

    logic [PT_BW-1:0]  pcnt;      // collect-side point counter
    logic [PT_BW-1:0]  pt_cnt;    // drain-side point of next element
    logic [CH_BW-1:0]  ch_cnt;    // drain-side channel of next element
    logic [IDX_BW-1:0] idx_cnt;   // flattened index of next element

    logic              soft_rst;
    logic              in_take;
    logic              hs_last;
    logic              load;
    logic [IBW-1:0]    elem_sel;

    assign soft_rst = !reset_n || i_clear;
    assign in_take  = (state_q == COLLECT) && i_in_valid;
    assign hs_last  = o_ot_valid && i_ot_ready && o_ot_last;

    // Output register is refilled either on the first DRAIN cycle (empty)
    // or on every non-final handshake, giving bubble-free back-to-back beats.
    assign load = (state_q == DRAIN) &&
                  (!o_ot_valid || (i_ot_ready && !o_ot_last));

    always_comb begin
        elem_sel = mem[pt_cnt][int'(ch_cnt)*IBW +: IBW];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (in_take && pcnt == PT_BW'(NPTS-1)) state_d = DRAIN;
            DRAIN:   if (hs_last)                           state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_rst) state_q <= COLLECT;
        else          state_q <= state_d;
    end

    // Frame buffer needs no reset.
    always_ff @(posedge clk) begin
        if (!soft_rst && in_take) mem[pcnt] <= i_in_fmap;
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            pcnt         <= '0;
            pt_cnt       <= '0;
            ch_cnt       <= '0;
            idx_cnt      <= '0;
            o_ot_valid   <= 1'b0;
            o_ot_data    <= '0;
            o_ot_index   <= '0;
            o_ot_last    <= 1'b0;
            o_frame_done <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_frame_done <= hs_last;

            if (state_q == DRAIN && i_in_valid) o_overflow <= 1'b1;

            if (in_take) begin
                if (pcnt == PT_BW'(NPTS-1)) pcnt <= '0;
                else                        pcnt <= pcnt + 1'b1;
            end

            if (hs_last) begin
                o_ot_valid <= 1'b0;
                o_ot_last  <= 1'b0;
            end else if (load) begin
                o_ot_valid <= 1'b1;
                o_ot_data  <= elem_sel;
                o_ot_index <= idx_cnt;
                o_ot_last  <= (idx_cnt == IDX_BW'(TOTAL-1));
                // Counters wrap to zero on the final load, ready for next frame.
                if (idx_cnt == IDX_BW'(TOTAL-1)) idx_cnt <= '0;
                else                             idx_cnt <= idx_cnt + 1'b1;
                if (pt_cnt == PT_BW'(NPTS-1)) begin
                    pt_cnt <= '0;
                    if (ch_cnt == CH_BW'(CI-1)) ch_cnt <= '0;
                    else                        ch_cnt <= ch_cnt + 1'b1;
                end else begin
                    pt_cnt <= pt_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/stage2_pool_collector.md
Name: stage2_pool_collector

Overview:
- Receiving end of the stage-2 pooling output stream: captures per-point, all-channel pooled vectors from the pooling core (valid-strobed, no backpressure) into an on-chip frame buffer.
- Once a full pooled frame (POOL_W x POOL_H points) is captured, drains it as a flattened, one-element-per-beat stream with valid/ready handshake to the downstream fully-connected stage.
- Detects and flags input arriving while the buffer cannot accept it.

Parameters:
- CI, 3, channels per input point.
- IBW, 19, signed bit width of one channel value.
- POOL_W, 4, pooled frame width (points per row).
- POOL_H, 4, pooled frame height (rows).
- IDX_BW, 6, width of flattened index; must satisfy 2^IDX_BW >= CI*POOL_W*POOL_H.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- i_clear  in  1  synchronous soft clear; same effect as reset; lower priority than reset_n.
- i_in_valid  in  1  one pooled point present this cycle.
- i_in_fmap  in  CI*IBW  point vector; channel ch at bits [ch*IBW +: IBW], signed.
- o_ot_valid  out  1  flattened element valid.
- i_ot_ready  in  1  downstream accepts element when o_ot_valid & i_ot_ready.
- o_ot_data  out  IBW  signed flattened element.
- o_ot_index  out  IDX_BW  flattened index of o_ot_data.
- o_ot_last  out  1  high with final element (index CI*POOL_W*POOL_H-1).
- o_frame_done  out  1  one-cycle pulse after last element handshake.
- o_overflow  out  1  sticky: input point dropped.

Behaviour:
- Reset/clear: all outputs 0, state COLLECT, point counter 0, element counter 0. Buffer contents need not be cleared. Applies mid-collection or mid-drain; partial frame discarded.
- State COLLECT:
  - Each cycle with i_in_valid=1 stores the point at counter p (raster order, p = row*POOL_W + col) and increments p.
  - Gaps of any length between valid points are allowed.
- Transition to DRAIN:
  - If the final point (p = POOL_W*POOL_H-1) is sampled in cycle N, the state is DRAIN in N+1.
  - First o_ot_valid=1 is in cycle N+2, index 0.
- Flattened order: channel-major. index = ch*POOL_H*POOL_W + p. Element = channel ch of stored point p, bit-exact with no rescaling or saturation.
- State DRAIN:
  - o_ot_valid stays 1 until the last element is accepted.
  - While i_ot_ready=0, o_ot_data, o_ot_index and o_ot_last hold stable.
  - On each handshake, the next element appears in the following cycle. Back-to-back handshakes give 1 element per cycle, with no bubbles after the first.
- Drain end:
  - In the cycle after the handshake with o_ot_last=1: o_ot_valid=0, o_ot_last=0, o_frame_done=1 for exactly 1 cycle, state COLLECT with p=0.
  - A point arriving in that same cycle is accepted as point 0 of the next frame.
- Overflow:
  - i_in_valid=1 while in DRAIN (including the N+1 cycle) drops the point and sets o_overflow=1.
  - o_overflow stays set until reset or i_clear.
  - Buffer contents and drain sequence are unaffected.
- Simultaneous events: reset_n=0 overrides everything. i_clear=1 together with i_in_valid drops the point with no overflow flag.
- o_ot_data is registered (no combinational path from i_in_fmap). o_ot_valid has no combinational dependence on i_ot_ready.

Test Plan:
- Basic frame: 16 consecutive points with ch0=k, ch1=100+k, ch2=-k (k=0..15), i_ot_ready=1.
  -> First o_ot_valid 2 cycles after point 15.
  -> 48 contiguous beats: 0..15, 100..115, 0,-1..-15.
  -> o_ot_last at index 47; o_frame_done pulse one cycle later.
- Backpressure: same frame, i_ot_ready random 50%.
  -> Identical 48-element sequence, no duplicates or skips; data/index stable during every ready=0 cycle.
- Sparse input: valid every 3rd cycle.
  -> Same stored frame and output order; DRAIN entered cycle after the 16th point.
- Overflow: 3 points injected during DRAIN.
  -> o_overflow=1 and stays 1; drained values match the original frame.
  -> After i_clear: o_overflow=0, state COLLECT.
- Reset mid-operation: reset_n low for 1 cycle after 7 points, then a fresh 16-point frame.
  -> Only the fresh frame is output, indices from 0.
  -> Repeat with reset during drain at index 20: o_ot_valid=0 next cycle, no o_frame_done.
- Extremes and back-to-back frames: values -2^18 and 2^18-1 on all channels.
  -> Output bit-exact.
  -> A second frame starting in the o_frame_done cycle is collected fully, point 0 included.
